// File: rtl/booth_mul_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller:
// FSM state encodings, accumulator mux codes and ALU operation codes.
package booth_mul_ctrl_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] ACC_ZERO = 2'b00;
  localparam logic [1:0] ACC_ALU  = 2'b01;
  localparam logic [1:0] ACC_PASS = 2'b10;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/booth_mul_ctrl_iter_cnt.sv
// Booth iteration counter: loaded with N, decremented once per iteration,
// flags the final iteration when the count reaches one. Never wraps below zero.
module booth_mul_ctrl_iter_cnt
  import booth_mul_ctrl_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(N);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth multiplier controller: sequences operand load, accumulator clear,
// N add/sub/pass-and-shift iterations, then holds done until the host acknowledges.
module booth_mul_ctrl
  import booth_mul_ctrl_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_ack,
  input  logic       i_q0,
  input  logic       i_qm1,
  output logic       o_ld_mq,
  output logic [1:0] o_acc_sel,
  output logic       o_add_sub,
  output logic       o_ld_acc,
  output logic       o_shift_q,
  output logic       o_busy,
  output logic       o_done
);

  state_t r_state;
  state_t w_next;
  logic   r_done;
  logic   w_cnt_load;
  logic   w_cnt_dec;
  logic   w_last;

  booth_mul_ctrl_iter_cnt #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_last (w_last)
  );

  // o_done lags entry to DONE by one edge and drops on the same edge that accepts i_ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE) && !(i_ack && r_done);
    end
  end

  always_comb begin
    w_next     = r_state;
    o_ld_mq    = 1'b0;
    o_acc_sel  = ACC_ZERO;
    o_add_sub  = ALU_ADD;
    o_ld_acc   = 1'b0;
    o_shift_q  = 1'b0;
    o_busy     = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_ld_mq = i_start && !i_rst;
        if (i_start) begin
          w_next = S_INIT;
        end
      end

      S_INIT: begin
        o_ld_acc   = 1'b1;
        o_acc_sel  = ACC_ZERO;
        o_busy     = 1'b1;
        w_cnt_load = 1'b1;
        w_next     = S_ITER;
      end

      // Booth recoding of {Q[0],Q[-1]} is decoded in the same cycle it is consumed.
      S_ITER: begin
        o_ld_acc  = 1'b1;
        o_shift_q = 1'b1;
        o_busy    = 1'b1;
        w_cnt_dec = 1'b1;
        case ({i_q0, i_qm1})
          2'b10: begin
            o_acc_sel = ACC_ALU;
            o_add_sub = ALU_SUB;
          end
          2'b01: begin
            o_acc_sel = ACC_ALU;
            o_add_sub = ALU_ADD;
          end
          default: begin
            o_acc_sel = ACC_PASS;
            o_add_sub = ALU_ADD;
          end
        endcase
        if (w_last) begin
          w_next = S_DONE;
        end
      end

      S_DONE: begin
        if (i_ack && r_done) begin
          w_next = S_IDLE;
        end
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign o_done = r_done;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl driving a behavioural Booth datapath;
// checks products, per-iteration operation decode, done latency and handshake corners.
module tb_booth_mul_ctrl;

  localparam logic [2:0] OP_PASS = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;

  typedef struct {
    string      name;
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] prod;
    logic [11:0] ops;
  } vec_t;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic       i_ack;
  logic       o_ld_mq;
  logic [1:0] o_acc_sel;
  logic       o_add_sub;
  logic       o_ld_acc;
  logic       o_shift_q;
  logic       o_busy;
  logic       o_done;

  logic [3:0] opM;
  logic [3:0] opQ;
  logic [3:0] dpM;
  logic [3:0] dpQ;
  logic       dpQm1;
  logic [4:0] dpA;
  logic [4:0] dpMExt;
  logic [4:0] dpSum;

  int passCnt  = 0;
  int totalCnt = 0;

  vec_t vecs[6];

  booth_mul_ctrl dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_ack     (i_ack),
    .i_q0      (dpQ[0]),
    .i_qm1     (dpQm1),
    .o_ld_mq   (o_ld_mq),
    .o_acc_sel (o_acc_sel),
    .o_add_sub (o_add_sub),
    .o_ld_acc  (o_ld_acc),
    .o_shift_q (o_shift_q),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural datapath: 5-bit accumulator so that -8 * -8 does not overflow.
  assign dpMExt = {dpM[3], dpM};
  assign dpSum  = (o_acc_sel == 2'b00) ? 5'd0 :
                  (o_acc_sel == 2'b01) ? (o_add_sub ? (dpA - dpMExt) : (dpA + dpMExt)) :
                  dpA;

  always @(posedge i_clk) begin
    if (o_ld_mq) begin
      dpM   <= opM;
      dpQ   <= opQ;
      dpQm1 <= 1'b0;
    end
    if (o_ld_acc) begin
      if (o_shift_q) begin
        dpA   <= {dpSum[4], dpSum[4:1]};
        dpQ   <= {dpSum[0], dpQ[3:1]};
        dpQm1 <= dpQ[0];
      end else begin
        dpA <= dpSum;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one multiplication; latency counts edges after the edge that samples i_start.
  task automatic applyStimulus(input logic [3:0] m, input logic [3:0] q, input bit keepStart,
                               output logic [7:0] prod, output logic [11:0] ops,
                               output int latency, output int busyCnt,
                               output int conflicts, output bit timedOut);
    ops       = '0;
    latency   = 0;
    busyCnt   = 0;
    conflicts = 0;
    timedOut  = 1'b1;
    @(negedge i_clk);
    opM     = m;
    opQ     = q;
    i_start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (!keepStart) i_start = 1'b0;
      if (o_busy) busyCnt++;
      if (o_shift_q) ops = {ops[8:0], o_acc_sel, o_add_sub};
      if (o_ld_mq && o_ld_acc) conflicts++;
      if (o_done) begin
        latency  = c - 1;
        timedOut = 1'b0;
        break;
      end
    end
    prod = {dpA[3:0], dpQ};
  endtask

  task automatic ackDone(input string name, input bit withStart);
    @(negedge i_clk);
    i_ack   = 1'b1;
    i_start = withStart;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ack = 1'b0;
    checkOutput({name, "_doneLowAfterAck"}, {31'd0, o_done}, 32'd0);
    checkOutput({name, "_idleAfterAck"}, {31'd0, o_busy}, 32'd0);
    i_start = 1'b0;
    if (withStart) begin
      @(posedge i_clk);
      @(negedge i_clk);
      checkOutput({name, "_startIgnoredWithAck"}, {31'd0, o_busy}, 32'd0);
    end
  endtask

  task automatic runAndCheck(input string name, input logic [3:0] m, input logic [3:0] q,
                             input logic [7:0] expProd, input bit keepStart);
    logic [7:0]  prod;
    logic [11:0] ops;
    int          latency;
    int          busyCnt;
    int          conflicts;
    bit          timedOut;
    applyStimulus(m, q, keepStart, prod, ops, latency, busyCnt, conflicts, timedOut);
    checkOutput({name, "_timeout"}, {31'd0, timedOut}, 32'd0);
    checkOutput({name, "_product"}, {24'd0, prod}, {24'd0, expProd});
    checkOutput({name, "_latency"}, latency, 32'd6);
    checkOutput({name, "_busyCycles"}, busyCnt, 32'd5);
  endtask

  initial begin
    logic [7:0]  prod;
    logic [11:0] ops;
    int          latency;
    int          busyCnt;
    int          conflicts;
    bit          timedOut;
    int          bad;

    vecs[0] = '{"m3_qm2",  4'h3, 4'hE, 8'hFA, {OP_PASS, OP_SUB, OP_PASS, OP_PASS}};
    vecs[1] = '{"m8_q8",   4'h8, 4'h8, 8'h40, {OP_PASS, OP_PASS, OP_PASS, OP_SUB}};
    vecs[2] = '{"m7_qm1",  4'h7, 4'hF, 8'hF9, {OP_SUB, OP_PASS, OP_PASS, OP_PASS}};
    vecs[3] = '{"m0_q5",   4'h0, 4'h5, 8'h00, {OP_SUB, OP_ADD, OP_SUB, OP_ADD}};
    vecs[4] = '{"m2_q3",   4'h2, 4'h3, 8'h06, {OP_SUB, OP_PASS, OP_ADD, OP_PASS}};
    vecs[5] = '{"mm3_q6",  4'hD, 4'h6, 8'hEE, {OP_PASS, OP_SUB, OP_PASS, OP_ADD}};

    i_rst   = 1'b1;
    i_start = 1'b1;
    i_ack   = 1'b0;
    opM     = '0;
    opQ     = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("resetOutputs",
                {23'd0, o_ld_mq, o_acc_sel, o_add_sub, o_ld_acc, o_shift_q, o_busy, o_done}, 32'd0);
    i_start = 1'b0;
    i_rst   = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].m, vecs[i].q, 1'b0, prod, ops, latency, busyCnt, conflicts, timedOut);
      checkOutput({vecs[i].name, "_timeout"}, {31'd0, timedOut}, 32'd0);
      checkOutput({vecs[i].name, "_product"}, {24'd0, prod}, {24'd0, vecs[i].prod});
      checkOutput({vecs[i].name, "_opSeq"}, {20'd0, ops}, {20'd0, vecs[i].ops});
      checkOutput({vecs[i].name, "_latency"}, latency, 32'd6);
      checkOutput({vecs[i].name, "_busyCycles"}, busyCnt, 32'd5);
      checkOutput({vecs[i].name, "_strobeConflict"}, conflicts, 32'd0);
      ackDone(vecs[i].name, 1'b0);
    end

    // i_start held high throughout the run and while done waits for ack.
    runAndCheck("startHeld", 4'h3, 4'hE, 8'hFA, 1'b1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (!o_done || o_ld_acc || o_shift_q || o_ld_mq || o_busy) bad++;
    end
    checkOutput("doneHeldNoStrobes", bad, 32'd0);
    ackDone("startHeld", 1'b1);
    runAndCheck("afterHold", 4'h7, 4'hF, 8'hF9, 1'b0);
    ackDone("afterHold", 1'b0);

    // Reset asserted during the second ITER cycle aborts the run.
    @(negedge i_clk);
    opM     = 4'h5;
    opQ     = 4'h5;
    i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("iterBeforeAbort", {31'd0, o_shift_q}, 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    checkOutput("abortOutputs",
                {23'd0, o_ld_mq, o_acc_sel, o_add_sub, o_ld_acc, o_shift_q, o_busy, o_done}, 32'd0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_done || o_busy) bad++;
    end
    checkOutput("abortStaysIdle", bad, 32'd0);
    runAndCheck("afterAbort", 4'h2, 4'h3, 8'h06, 1'b0);
    ackDone("afterAbort", 1'b0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
